ili9341_panel_model: RTL and testbench
======================================

Name: ili9341_panel_model

Overview:
- SPI receiver and ILI9341 command decoder: the display-side end of the 4-wire serial link that the driver transmits on.
- Oversamples the serial lines in the sysclk domain, assembles bytes (MSB first, SPI mode 0), and tags each byte as command or data from dc.
- Interprets the window and memory-write commands, then emits addressed RGB565 pixel writes.
- Serves as the bench-side panel model and as an on-chip loopback checker for the driver.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each serial input; minimum 2.
- MAX_X, 239: highest legal column address.
- MAX_Y, 319: highest legal page (row) address.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- spi_clk  in  1  serial clock from the driver (tft_clk); asynchronous to sysclk.
- spi_cs_n  in  1  chip select, active low (tft_cs).
- spi_dc  in  1  0 = command byte, 1 = data byte (tft_dc).
- spi_din  in  1  serial data, MSB first (tft_din).
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte; valid with byte_valid.
- byte_is_data  out  1  dc sampled with the 8th bit.
- cmd_code  out  8  last command byte received.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_data  out  16  RGB565 pixel, high byte first on the wire.
- pix_x  out  9  column address of pix_data.
- pix_y  out  9  page address of pix_data.
- param_err  out  1  one-cycle pulse when a CASET or PASET parameter set is rejected.
- frag_err  out  1  one-cycle pulse when cs rises with 1 to 7 bits pending.
- sleep_out  out  1  level; set by SLPOUT.
- disp_on  out  1  level; set by DISPON.

Behaviour:
- Clock ratio: spi_clk frequency must not exceed sysclk/4. Each spi_clk high and low phase lasts at least 2 sysclk cycles.
- Reset (rst_n=0 at a sysclk edge): all pulse outputs 0; byte_data, cmd_code, pix_data, pix_x, pix_y = 0; sleep_out = disp_on = 0; column window = 0..MAX_X; page window = 0..MAX_Y; bit counter = 0; decoder state = IDLE. Reset asserted mid-byte or mid-pixel discards all partial state.
- Byte receive:
  - Inputs pass through SYNC_STAGES flops.
  - A rising edge of synchronized spi_clk while synchronized cs_n = 0 shifts din into the LSB and increments the bit counter (3 bits).
  - On the 8th edge, dc is sampled and byte_valid pulses on the next sysclk cycle. The counter wraps to 0.
  - Rising edges while cs_n = 1 are ignored.
- cs_n rising: the bit counter clears. If the count was nonzero, frag_err pulses and the partial byte is dropped. Decoder state is kept, so parameters may span cs frames.
- Decoder states: IDLE, CASET_P, PASET_P, RAMWR_HI, RAMWR_LO, IGNORE.
- Any command byte updates cmd_code, aborts the current state (a dangling high pixel byte is discarded), then dispatches:
  - 0x01 SWRESET: windows to full range; sleep_out = 0; disp_on = 0; go to IDLE.
  - 0x10 SLPIN: sleep_out = 0. 0x11 SLPOUT: sleep_out = 1. 0x28 DISPOFF: disp_on = 0. 0x29 DISPON: disp_on = 1. All four go to IDLE.
  - 0x2A: go to CASET_P with the parameter index cleared. 0x2B: go to PASET_P with the index cleared.
  - 0x2C RAMWR: cursor = (col_start, page_start); go to RAMWR_HI.
  - Any other opcode: go to IGNORE, which consumes data bytes silently.
- CASET_P / PASET_P:
  - Collect 4 data bytes: SC[15:8], SC[7:0], EC[15:8], EC[7:0].
  - On the 4th byte, apply the window only if SC ≤ EC and EC ≤ MAX_X (MAX_Y for PASET). Otherwise leave the window unchanged and pulse param_err.
  - In both cases go to IDLE. Further data bytes in IDLE are ignored.
- RAMWR_HI: a data byte latches the high byte; go to RAMWR_LO.
- RAMWR_LO: a data byte completes the pixel. On the next cycle pix_valid = 1 with pix_data = {hi, lo} and pix_x/pix_y = cursor. Then advance the cursor:
  - x == col_end: x = col_start and y advances.
  - y == page_end at that point: y = page_start (wrap).
  - Return to RAMWR_HI.
- Latency: pix_valid asserts 1 sysclk after the byte_valid of the low byte.

Decomposition:
- Package ili9341_pkg holds: opcode constants (SWRESET, SLPIN, SLPOUT, DISPOFF, DISPON, CASET, PASET, RAMWR); the decoder state enum; the coordinate width (9).
- Sub-module spi_byte_rx: synchronizers, edge detect, shift register, bit counter, byte_valid/byte_is_data/frag_err generation.
- Command decoder, window registers and cursor live in the top.

Test Plan:
- Send cmd 0x11 then cmd 0x29 at sysclk/8 → two byte_valid pulses with byte_is_data = 0; sleep_out = 1; disp_on = 1; cmd_code = 0x29.
- Send CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR, then 5 pixels 0xF800, 0x07E0, 0x001F, 0xFFFF, 0x1234 → pix (10,20), (11,20), (10,21), (11,21), then wrap to (10,20) carrying 0x1234.
- Send CASET 00 05 00 03 → param_err pulse; the next RAMWR pixel lands at x = 0.
- Send 5 bits, raise cs_n, then send a full byte 0xA5 → frag_err pulse once; byte_data = 0xA5.
- After RAMWR, send high byte 0xAB, then cmd 0x00, then RAMWR 12 34 → exactly one pix_valid, with data 0x1234.
- Assert rst_n = 0 mid-pixel after CASET → all outputs at reset values; window restored to 0..239 / 0..319.

Source files
------------

// File: rtl/ili9341_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_pkg
// Brief    : Opcodes, decoder state codes and coordinate width shared by the
//            ILI9341 panel model.
// Revision : 1.0
// ============================================================================
package ili9341_pkg;

    localparam int c_coord_w = 9;

    localparam logic [7:0] c_op_swreset = 8'h01;
    localparam logic [7:0] c_op_slpin   = 8'h10;
    localparam logic [7:0] c_op_slpout  = 8'h11;
    localparam logic [7:0] c_op_dispoff = 8'h28;
    localparam logic [7:0] c_op_dispon  = 8'h29;
    localparam logic [7:0] c_op_caset   = 8'h2A;
    localparam logic [7:0] c_op_paset   = 8'h2B;
    localparam logic [7:0] c_op_ramwr   = 8'h2C;

    typedef logic [2:0] dec_state_t;

    localparam dec_state_t c_st_idle     = 3'd0;
    localparam dec_state_t c_st_caset_p  = 3'd1;
    localparam dec_state_t c_st_paset_p  = 3'd2;
    localparam dec_state_t c_st_ramwr_hi = 3'd3;
    localparam dec_state_t c_st_ramwr_lo = 3'd4;
    localparam dec_state_t c_st_ignore   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/ili9341_panel_model_if.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_panel_model_if
// Brief    : 4-wire serial link between the display driver and the panel.
// Revision : 1.0
// ============================================================================
interface ili9341_panel_model_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_dc;
    logic spi_din;

    modport master (output spi_clk, output spi_cs_n, output spi_dc, output spi_din);
    modport slave  (input  spi_clk, input  spi_cs_n, input  spi_dc, input  spi_din);
endinterface
`default_nettype wire

// File: rtl/ili9341_panel_model_spi_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_rx
// Brief    : Oversampling SPI mode-0 byte receiver with fragment detection.
// Revision : 1.0
// ============================================================================
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_dc,
    input  logic       spi_din,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       frag_err
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_clk_d;
    logic                   r_cs_d;
    logic [6:0]             r_shift;
    logic [2:0]             r_cnt;

    logic w_clk_s;
    logic w_cs_s;
    logic w_clk_rise;
    logic w_cs_rise;

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_clk_rise = w_clk_s & ~r_clk_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;

    // All four lines share one synchronizer depth so din/dc stay aligned with the clock.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_clk_sync <= '0;
            r_cs_sync  <= '1;
            r_dc_sync  <= '0;
            r_din_sync <= '0;
            r_clk_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  spi_cs_n};
            r_dc_sync  <= {r_dc_sync[SYNC_STAGES-2:0],  spi_dc};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi_din};
            r_clk_d    <= w_clk_s;
            r_cs_d     <= w_cs_s;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            frag_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frag_err   <= 1'b0;
            if (w_cs_rise) begin
                r_cnt    <= '0;
                frag_err <= (r_cnt != 3'd0);
            end else if (w_clk_rise && !w_cs_s) begin
                r_shift <= {r_shift[5:0], r_din_sync[SYNC_STAGES-1]};
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= {r_shift, r_din_sync[SYNC_STAGES-1]};
                    byte_is_data <= r_dc_sync[SYNC_STAGES-1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ili9341_panel_model.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_panel_model
// Brief    : ILI9341 command decoder producing addressed RGB565 pixel writes.
// Revision : 1.0
// ============================================================================
module ili9341_panel_model
    import ili9341_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_X       = 239,
    parameter int MAX_Y       = 319
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    ili9341_panel_model_if.slave spi,
    output logic                 byte_valid,
    output logic [7:0]           byte_data,
    output logic                 byte_is_data,
    output logic [7:0]           cmd_code,
    output logic                 pix_valid,
    output logic [15:0]          pix_data,
    output logic [c_coord_w-1:0] pix_x,
    output logic [c_coord_w-1:0] pix_y,
    output logic                 param_err,
    output logic                 frag_err,
    output logic                 sleep_out,
    output logic                 disp_on
);

    localparam logic [c_coord_w-1:0] c_max_x = c_coord_w'(MAX_X);
    localparam logic [c_coord_w-1:0] c_max_y = c_coord_w'(MAX_Y);

    dec_state_t             r_state;
    logic [1:0]             r_idx;
    logic [23:0]            r_par;
    logic [7:0]             r_hi;
    logic [c_coord_w-1:0]   r_col_start;
    logic [c_coord_w-1:0]   r_col_end;
    logic [c_coord_w-1:0]   r_page_start;
    logic [c_coord_w-1:0]   r_page_end;
    logic [c_coord_w-1:0]   r_cur_x;
    logic [c_coord_w-1:0]   r_cur_y;

    logic [15:0] w_sc;
    logic [15:0] w_ec;
    logic [15:0] w_lim;
    logic        w_par_ok;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .spi_clk      (spi.spi_clk),
        .spi_cs_n     (spi.spi_cs_n),
        .spi_dc       (spi.spi_dc),
        .spi_din      (spi.spi_din),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .frag_err     (frag_err)
    );

    // Full 16-bit compare so a nonzero high byte is rejected, not truncated.
    assign w_sc     = r_par[23:8];
    assign w_ec     = {r_par[7:0], byte_data};
    assign w_lim    = (r_state == c_st_caset_p) ? 16'(MAX_X) : 16'(MAX_Y);
    assign w_par_ok = (w_sc <= w_ec) && (w_ec <= w_lim);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_idx        <= '0;
            r_par        <= '0;
            r_hi         <= '0;
            r_col_start  <= '0;
            r_col_end    <= c_max_x;
            r_page_start <= '0;
            r_page_end   <= c_max_y;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            cmd_code     <= '0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            param_err    <= 1'b0;
            sleep_out    <= 1'b0;
            disp_on      <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            param_err <= 1'b0;
            if (byte_valid && !byte_is_data) begin
                cmd_code <= byte_data;
                r_idx    <= '0;
                r_state  <= c_st_idle;
                case (byte_data)
                    c_op_swreset: begin
                        r_col_start  <= '0;
                        r_col_end    <= c_max_x;
                        r_page_start <= '0;
                        r_page_end   <= c_max_y;
                        sleep_out    <= 1'b0;
                        disp_on      <= 1'b0;
                    end
                    c_op_slpin:   sleep_out <= 1'b0;
                    c_op_slpout:  sleep_out <= 1'b1;
                    c_op_dispoff: disp_on   <= 1'b0;
                    c_op_dispon:  disp_on   <= 1'b1;
                    c_op_caset:   r_state   <= c_st_caset_p;
                    c_op_paset:   r_state   <= c_st_paset_p;
                    c_op_ramwr: begin
                        r_cur_x <= r_col_start;
                        r_cur_y <= r_page_start;
                        r_state <= c_st_ramwr_hi;
                    end
                    default:      r_state   <= c_st_ignore;
                endcase
            end else if (byte_valid) begin
                case (r_state)
                    c_st_caset_p, c_st_paset_p: begin
                        r_idx <= r_idx + 2'd1;
                        r_par <= {r_par[15:0], byte_data};
                        if (r_idx == 2'd3) begin
                            r_state <= c_st_idle;
                            if (!w_par_ok) begin
                                param_err <= 1'b1;
                            end else if (r_state == c_st_caset_p) begin
                                r_col_start <= w_sc[c_coord_w-1:0];
                                r_col_end   <= w_ec[c_coord_w-1:0];
                            end else begin
                                r_page_start <= w_sc[c_coord_w-1:0];
                                r_page_end   <= w_ec[c_coord_w-1:0];
                            end
                        end
                    end
                    c_st_ramwr_hi: begin
                        r_hi    <= byte_data;
                        r_state <= c_st_ramwr_lo;
                    end
                    c_st_ramwr_lo: begin
                        pix_valid <= 1'b1;
                        pix_data  <= {r_hi, byte_data};
                        pix_x     <= r_cur_x;
                        pix_y     <= r_cur_y;
                        r_state   <= c_st_ramwr_hi;
                        // Raster order inside the window, wrapping back to its top-left.
                        if (r_cur_x == r_col_end) begin
                            r_cur_x <= r_col_start;
                            r_cur_y <= (r_cur_y == r_page_end) ? r_page_start
                                                               : r_cur_y + 1'b1;
                        end else begin
                            r_cur_x <= r_cur_x + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ili9341_panel_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ili9341_panel_model
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized command streams against a window/raster model.
// Revision : 1.0
// ============================================================================
module tb_ili9341_panel_model;

    localparam int MAX_X = 239;
    localparam int MAX_Y = 319;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    ili9341_panel_model_if spi_bus ();

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic [7:0]  cmd_code;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic        param_err;
    logic        frag_err;
    logic        sleep_out;
    logic        disp_on;

    ili9341_panel_model #(
        .SYNC_STAGES (2),
        .MAX_X       (MAX_X),
        .MAX_Y       (MAX_Y)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .spi          (spi_bus),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .cmd_code     (cmd_code),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .param_err    (param_err),
        .frag_err     (frag_err),
        .sleep_out    (sleep_out),
        .disp_on      (disp_on)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [8:0]  x;
        logic [8:0]  y;
    } pix_t;

    typedef struct {
        bit         dc;
        logic [7:0] b;
        bit         sleep;
        bit         disp;
        logic [7:0] cmd;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Monitor state, sampled on the falling edge.
    pix_t       got_pix[$];
    int         n_bytes = 0;
    int         n_frag  = 0;
    int         n_perr  = 0;
    int         lat_err = 0;
    logic [7:0] last_byte = '0;
    logic       last_is_data = 1'b0;
    logic       bv_prev = 1'b0;

    always @(negedge sysclk) begin
        if (pix_valid) begin
            got_pix.push_back(pix_t'({pix_data, pix_x, pix_y}));
            if (!bv_prev) lat_err++;
        end
        if (byte_valid) begin
            n_bytes++;
            last_byte    = byte_data;
            last_is_data = byte_is_data;
        end
        if (frag_err)  n_frag++;
        if (param_err) n_perr++;
        bv_prev = byte_valid;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    task automatic settle();
        repeat (10) @(posedge sysclk);
        #1;
    endtask

    task automatic send_bits(input bit dc, input logic [7:0] v, input int n);
        spi_bus.spi_cs_n = 1'b0;
        spi_bus.spi_dc   = dc;
        for (int i = 7; i > 7 - n; i--) begin
            spi_bus.spi_clk = 1'b0;
            spi_bus.spi_din = v[i];
            half();
            spi_bus.spi_clk = 1'b1;
            half();
        end
        spi_bus.spi_clk = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic cs_high();
        spi_bus.spi_clk = 1'b0;
        half();
        spi_bus.spi_cs_n = 1'b1;
        half();
    endtask

    task automatic win(input logic [7:0] op, input logic [15:0] sc, input logic [15:0] ec);
        cmd(op);
        dat(sc[15:8]);
        dat(sc[7:0]);
        dat(ec[15:8]);
        dat(ec[7:0]);
    endtask

    task automatic pixel(input logic [15:0] d);
        dat(d[15:8]);
        dat(d[7:0]);
    endtask

    function automatic pix_t mk(input logic [15:0] d, input int x, input int y);
        pix_t p;
        p.d = d;
        p.x = 9'(x);
        p.y = 9'(y);
        return p;
    endfunction

    task automatic cmp_pix(input string tag, input pix_t exp[$]);
        check({tag, " count"}, 64'(got_pix.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_pix.size(); i++)
            check($sformatf("%s pix%0d", tag, i), 64'(got_pix[i]), 64'(exp[i]));
        got_pix.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " byte_valid"},  64'(byte_valid), 0);
        check({tag, " pix_valid"},   64'(pix_valid), 0);
        check({tag, " param_err"},   64'(param_err), 0);
        check({tag, " frag_err"},    64'(frag_err), 0);
        check({tag, " byte_data"},   64'(byte_data), 0);
        check({tag, " cmd_code"},    64'(cmd_code), 0);
        check({tag, " pix_data"},    64'(pix_data), 0);
        check({tag, " pix_xy"},      64'({pix_x, pix_y}), 0);
        check({tag, " sleep_disp"},  64'({sleep_out, disp_on}), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        pix_t exp[$];
        int   perr0;
        int   m_cs, m_ce, m_ps, m_pe, w, h, k, m_perr;
        bit   m_sleep, m_disp;
        logic [7:0] m_cmd;
        logic [7:0] others[5];

        vecs[0] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h11};
        vecs[1] = '{1'b0, 8'h29, 1'b1, 1'b1, 8'h29};
        vecs[2] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h29};
        vecs[3] = '{1'b0, 8'h28, 1'b1, 1'b0, 8'h28};
        vecs[4] = '{1'b0, 8'h10, 1'b0, 1'b0, 8'h10};
        vecs[5] = '{1'b0, 8'h29, 1'b0, 1'b1, 8'h29};
        vecs[6] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11};
        vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h01};
        others  = '{8'h00, 8'h36, 8'h3A, 8'hB1, 8'h2D};

        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_cs_n = 1'b1;
        spi_bus.spi_dc   = 1'b0;
        spi_bus.spi_din  = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge sysclk);
        @(negedge sysclk);
        check_reset_vals("reset");
        #1;
        rst_n = 1'b1;
        settle();

        // Command/level decode table
        for (int i = 0; i < 8; i++) begin
            send_bits(vecs[i].dc, vecs[i].b, 8);
            settle();
            check($sformatf("vec%0d bytes", i), 64'(n_bytes), 64'(i + 1));
            check($sformatf("vec%0d byte", i), 64'({last_is_data, last_byte}), 64'({vecs[i].dc, vecs[i].b}));
            check($sformatf("vec%0d levels", i), 64'({sleep_out, disp_on}), 64'({vecs[i].sleep, vecs[i].disp}));
            check($sformatf("vec%0d cmd", i), 64'(cmd_code), 64'(vecs[i].cmd));
        end
        cs_high();

        // Small window with raster wrap
        win(8'h2A, 16'd10, 16'd11);
        win(8'h2B, 16'd20, 16'd21);
        cmd(8'h2C);
        pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F); pixel(16'hFFFF); pixel(16'h1234);
        cs_high();
        settle();
        exp = '{mk(16'hF800, 10, 20), mk(16'h07E0, 11, 20), mk(16'h001F, 10, 21),
                mk(16'hFFFF, 11, 21), mk(16'h1234, 10, 20)};
        cmp_pix("window", exp);

        // Rejected and boundary window parameters
        cmd(8'h01);
        perr0 = n_perr;
        win(8'h2A, 16'd5, 16'd3);
        settle();
        check("caset sc>ec perr", 64'(n_perr - perr0), 1);
        cmd(8'h2C);
        pixel(16'hBEEF);
        settle();
        exp = '{mk(16'hBEEF, 0, 0)};
        cmp_pix("after perr", exp);
        win(8'h2A, 16'd0, 16'd239);
        win(8'h2A, 16'd0, 16'd240);
        win(8'h2B, 16'd0, 16'd319);
        win(8'h2B, 16'd0, 16'd320);
        settle();
        check("boundary perr", 64'(n_perr - perr0), 3);
        win(8'h2A, 16'd239, 16'd239);
        win(8'h2B, 16'd319, 16'd319);
        cmd(8'h2C);
        pixel(16'h0001); pixel(16'h0002);
        cs_high();
        settle();
        exp = '{mk(16'h0001, 239, 319), mk(16'h0002, 239, 319)};
        cmp_pix("corner", exp);

        // Fragment on cs rise
        n_frag = 0;
        send_bits(1'b1, 8'hFF, 5);
        cs_high();
        dat(8'hA5);
        cs_high();
        settle();
        check("frag count", 64'(n_frag), 1);
        check("frag next byte", 64'(last_byte), 64'(8'hA5));

        // Dangling high byte dropped by a command
        cmd(8'h01);
        cmd(8'h2C);
        dat(8'hAB);
        cmd(8'h00);
        cmd(8'h2C);
        pixel(16'h1234);
        cs_high();
        settle();
        exp = '{mk(16'h1234, 0, 0)};
        cmp_pix("dangling", exp);

        // Randomized command streams against a raster model
        cmd(8'h01);
        cs_high();
        settle();
        m_cs = 0; m_ce = MAX_X; m_ps = 0; m_pe = MAX_Y;
        m_sleep = 0; m_disp = 0; m_cmd = 8'h01;
        m_perr = 0;
        perr0 = n_perr;
        exp.delete();
        for (int t = 0; t < 25; t++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind <= 1) begin
                int lim, sc, ec, mode;
                lim  = (kind == 0) ? MAX_X : MAX_Y;
                mode = $urandom_range(0, 3);
                sc   = $urandom_range(0, lim - 3);
                ec   = sc + $urandom_range(0, 3);
                if (mode == 1) begin
                    sc = $urandom_range(1, lim);
                    ec = $urandom_range(0, sc - 1);
                end else if (mode == 2) begin
                    ec = lim + 1 + $urandom_range(0, 300);
                end
                m_cmd = (kind == 0) ? 8'h2A : 8'h2B;
                cmd(m_cmd);
                dat(8'(sc >> 8)); dat(8'(sc));
                if ($urandom_range(0, 1) == 1) cs_high();
                dat(8'(ec >> 8)); dat(8'(ec));
                if (sc <= ec && ec <= lim) begin
                    if (kind == 0) begin m_cs = sc; m_ce = ec; end
                    else           begin m_ps = sc; m_pe = ec; end
                end else begin
                    m_perr++;
                end
            end else if (kind <= 3) begin
                int n;
                n = $urandom_range(1, 10);
                w = m_ce - m_cs + 1;
                h = m_pe - m_ps + 1;
                m_cmd = 8'h2C;
                cmd(8'h2C);
                for (k = 0; k < n; k++) begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    pixel(d);
                    exp.push_back(mk(d, m_cs + (k % w), m_ps + ((k / w) % h)));
                end
                if ($urandom_range(0, 3) == 0) dat(8'($urandom));
            end else if (kind == 4) begin
                m_cmd = others[$urandom_range(0, 4)];
                cmd(m_cmd);
                for (int j = $urandom_range(0, 3); j > 0; j--) dat(8'($urandom));
            end else begin
                case ($urandom_range(0, 3))
                    0: begin m_cmd = 8'h10; m_sleep = 0; end
                    1: begin m_cmd = 8'h11; m_sleep = 1; end
                    2: begin m_cmd = 8'h28; m_disp = 0; end
                    default: begin m_cmd = 8'h29; m_disp = 1; end
                endcase
                cmd(m_cmd);
            end
            if ($urandom_range(0, 1) == 1) cs_high();
        end
        cs_high();
        settle();
        cmp_pix("random", exp);
        check("random perr", 64'(n_perr - perr0), 64'(m_perr));
        check("random levels", 64'({sleep_out, disp_on}), 64'({m_sleep, m_disp}));
        check("random cmd", 64'(cmd_code), 64'(m_cmd));

        // Reset in the middle of a pixel and of a byte
        win(8'h2A, 16'd10, 16'd11);
        cmd(8'h2C);
        dat(8'hAB);
        send_bits(1'b1, 8'hCD, 3);
        perr0 = n_frag;
        rst_n = 1'b0;
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_cs_n = 1'b1;
        repeat (6) @(posedge sysclk);
        @(negedge sysclk);
        check_reset_vals("midreset");
        #1;
        rst_n = 1'b1;
        got_pix.delete();
        settle();
        cmd(8'h2C);
        pixel(16'h5A5A); pixel(16'hA5A5);
        win(8'h2A, 16'd0, 16'd0);
        cmd(8'h2C);
        pixel(16'h0F0F); pixel(16'hF0F0);
        cs_high();
        settle();
        exp = '{mk(16'h5A5A, 0, 0), mk(16'hA5A5, 1, 0), mk(16'h0F0F, 0, 0), mk(16'hF0F0, 0, 1)};
        cmp_pix("post reset", exp);
        check("no frag on reset", 64'(n_frag - perr0), 0);
        check("pix latency", 64'(lat_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
